count_seq_monitor: RTL
======================

Name: count_seq_monitor

Overview:
- Downstream checker for the free-running W-bit up-counter in this codebase.
- Samples the counter's Count output and locks onto the modulo-2^W increment sequence.
- Reports lock status, sequence errors, detected counter resets and wrap events through registered status outputs and statistics counters.
- Sits between the counter and debug/status logic.

Parameters:
- W, 2, width of the monitored count.
- ERR_W, 8, width of err_cnt and wrap_cnt.
- LOCK_CYCLES, 2, consecutive correct increments required to lock (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- count_in  input  W  counter value being monitored.
- in_valid  input  1  count_in is sampled only when high.
- clr  input  1  synchronous clear of statistics.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse on a sequence error.
- rst_seen  output  1  one-cycle pulse when a counter reset is detected.
- err_sticky  output  1  set on any error, cleared only by clr or rst.
- err_cnt  output  ERR_W  saturating error count.
- wrap_cnt  output  ERR_W  wrap count, wraps modulo 2^ERR_W.

Behaviour:

Reset and timing:
- rst low, asynchronously: state=UNLOCKED, prev=0, match_cnt=0, all outputs 0.
- All outputs are registered: the response appears on the clk edge after the sampling edge (1-cycle latency).

Sampling and state machine:
- in_valid=0: state, prev, match_cnt and counters hold; err_pulse and rst_seen are 0.
- Terms: nxt=(prev+1) mod 2^W; MAX=2^W-1.
- On every valid sample, prev<=count_in.
- UNLOCKED, on valid: go to ACQUIRE, match_cnt=0.
- ACQUIRE, on valid:
  - count_in==nxt: match_cnt++; when it reaches LOCKED_CYCLES, go to LOCKED.
  - Otherwise: match_cnt=0, stay in ACQUIRE, no error flagged.
- LOCKED, on valid:
  - count_in==nxt: stay in LOCKED. If prev==MAX (wrap to 0), wrap_cnt++.
  - count_in==0 and prev!=MAX: counter-reset detected. rst_seen pulse, go to ACQUIRE with match_cnt=0, no error.
  - Any other value: err_pulse, err_sticky=1, err_cnt+1 (saturating at 2^ERR_W-1), go to ACQUIRE with match_cnt=0.
- locked deasserts on the same edge the state leaves LOCKED.

clr:
- Zeroes err_cnt, wrap_cnt and err_sticky.
- Has priority over a coincident increment or set: the simultaneous event is not counted, but err_pulse/rst_seen still fire.
- Does not affect state.

Reset mid-operation: drops to UNLOCKED immediately; relock starts from the next valid sample.

Optional Feature:
- COUNT_MON_HOLD_EN defined: in LOCKED, count_in==prev is accepted as a hold. Stays LOCKED, no error, no wrap.
- Undefined: a hold in LOCKED is a sequence error.
- In ACQUIRE, a hold leaves match_cnt unchanged when defined and resets it to 0 when undefined.

Decomposition:
- Package count_mon_pkg:
  - state enum {UNLOCKED, ACQUIRE, LOCKED}.
  - Helper functions for nxt and MAX given W.
- One natural sub-module: sat_counter (ERR_W-bit, with inc, clr and saturate-enable), instantiated for err_cnt (saturating) and wrap_cnt (wrapping).

Test Plan (W=2, LOCK_CYCLES=2 unless stated):
1. Lock and wrap: rst low 10 ns then high; valid samples 0,1,2,3,0,1 → locked=1 after sample 2; wrap_cnt=1 after the 3→0 sample; err_cnt=0.
2. Sequence error: locked at count 1, feed 3 → err_pulse for one cycle, err_cnt=1, err_sticky=1, locked=0; feed 0,1 → relock.
3. Counter reset: locked at count 2, feed 0 (counter reset mid-run) → rst_seen pulse, err_cnt unchanged, locked=0; feed 1,2 → locked=1.
4. Valid gating: in_valid=0 for 5 cycles with count_in toggling randomly → no output or state change; resume with the correct next value → stays locked.
5. Saturation: ERR_W=2, five error/relock rounds → err_cnt=3. Assert clr in the same cycle as a sixth error → err_cnt=0, err_sticky=0, err_pulse=1.
6. Hold: locked at 2, feed 2 → err_pulse without COUNT_MON_HOLD_EN; locked stays 1 and err_cnt=0 with COUNT_MON_HOLD_EN. Also assert rst low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the counter sequence monitor.
//   state_e    : monitor lock state
//   count_max  : largest value of a w-bit counter (2^w - 1), valid for w < 32
//   next_count : modulo-2^w successor of v
package count_mon_pkg;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StAcquire  = 2'd1,
    StLocked   = 2'd2
  } state_e;

  function automatic logic [31:0] count_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] next_count(input int unsigned w, input logic [31:0] v);
    return (v + 32'd1) & count_max(w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter with synchronous clear and optional saturation.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset, clears the count
//   clr_i    : synchronous clear, wins over a coincident increment
//   inc_i    : add one this cycle
//   sat_en_i : 1 = stick at all-ones, 0 = wrap modulo 2^Width
//   cnt_o    : current count
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             sat_en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(sat_en_i && (cnt_q == '1))) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Downstream checker for a free-running W-bit up-counter. Locks onto the
// modulo-2^W increment sequence and reports lock, sequence errors, counter
// resets and wraps. All outputs are registered (one cycle after sampling).
// Optional build macro: COUNT_MON_HOLD_EN -- accept count_in == previous
// sample as a legal hold (no error in LOCKED, match run kept in ACQUIRE).
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   count_in_i   : monitored counter value
//   in_valid_i   : count_in_i is sampled only when high
//   clr_i        : synchronous clear of err_cnt_o, wrap_cnt_o, err_sticky_o
//   locked_o     : high while locked
//   err_pulse_o  : one-cycle pulse on a sequence error
//   rst_seen_o   : one-cycle pulse when a counter reset is detected
//   err_sticky_o : set on any error until clr_i or reset
//   err_cnt_o    : saturating error count
//   wrap_cnt_o   : wrap count, modulo 2^ERR_W
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned W           = 2,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned LOCK_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [W-1:0]     count_in_i,
  input  logic             in_valid_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             rst_seen_o,
  output logic             err_sticky_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [ERR_W-1:0] wrap_cnt_o
);

  localparam int unsigned McW = $clog2(LOCK_CYCLES + 1);

  state_e           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [McW-1:0]   match_q, match_d;
  logic             err_pulse_q, err_pulse_d;
  logic             rst_seen_q, rst_seen_d;
  logic             sticky_q, sticky_d;
  logic             wrap_inc;

  logic [W-1:0] nxt, max_v;
  logic         is_next, hold_ok;

  assign nxt     = W'(next_count(W, 32'(prev_q)));
  assign max_v   = W'(count_max(W));
  assign is_next = (count_in_i == nxt);
`ifdef COUNT_MON_HOLD_EN
  assign hold_ok = (count_in_i == prev_q);
`else
  assign hold_ok = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_d     = match_q;
    err_pulse_d = 1'b0;
    rst_seen_d  = 1'b0;
    wrap_inc    = 1'b0;
    if (in_valid_i) begin
      prev_d = count_in_i;
      unique case (state_q)
        StUnlocked: begin
          state_d = StAcquire;
          match_d = '0;
        end
        StAcquire: begin
          if (is_next) begin
            if (32'(match_q) + 32'd1 >= LOCK_CYCLES) begin
              state_d = StLocked;
              match_d = '0;
            end else begin
              match_d = match_q + McW'(1);
            end
          end else if (!hold_ok) begin
            match_d = '0;
          end
        end
        StLocked: begin
          if (is_next) begin
            wrap_inc = (prev_q == max_v);
          end else if (hold_ok) begin
            // Legal hold: stay locked, nothing reported.
          end else if (count_in_i == '0) begin
            // prev != MAX is implied here, otherwise 0 would have been nxt.
            rst_seen_d = 1'b1;
            state_d    = StAcquire;
            match_d    = '0;
          end else begin
            err_pulse_d = 1'b1;
            state_d     = StAcquire;
            match_d     = '0;
          end
        end
        default: begin
          state_d = StUnlocked;
          match_d = '0;
        end
      endcase
    end
    // clr only touches statistics; the pulses above still fire.
    sticky_d = clr_i ? 1'b0 : (sticky_q | err_pulse_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StUnlocked;
      prev_q      <= '0;
      match_q     <= '0;
      err_pulse_q <= 1'b0;
      rst_seen_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      err_pulse_q <= err_pulse_d;
      rst_seen_q  <= rst_seen_d;
      sticky_q    <= sticky_d;
    end
  end

  sat_counter #(
    .Width (ERR_W)
  ) u_err_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .inc_i    (err_pulse_d),
    .sat_en_i (1'b1),
    .cnt_o    (err_cnt_o)
  );

  sat_counter #(
    .Width (ERR_W)
  ) u_wrap_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .inc_i    (wrap_inc),
    .sat_en_i (1'b0),
    .cnt_o    (wrap_cnt_o)
  );

  assign locked_o     = (state_q == StLocked);
  assign err_pulse_o  = err_pulse_q;
  assign rst_seen_o   = rst_seen_q;
  assign err_sticky_o = sticky_q;

endmodule
